muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
Multi-cycle multiply/divide sequencer that owns the architectural HI/LO registers for the CPU datapath. Accepts MULT/MULTU/DIV/DIVU requests, computes one bit per cycle with a shift-add or restoring-divide engine, and holds the pipeline via busy_o. Replaces the single-cycle loop-unrolled mul/div path in the ALU so that the ALU keeps only its 1-cycle operations.

Parameters:
- XLEN, 32, operand width; HI/LO are XLEN each; iteration count = XLEN.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  request valid; sampled only in IDLE.
- aluop_i  in  5  operation code; `ALUOP_MULT, `ALUOP_MULTU, `ALUOP_DIV, `ALUOP_DIVU from defines.v.
- src0_i  in  XLEN  multiplicand / dividend (rs).
- src1_i  in  XLEN  multiplier / divisor (rt).
- flush_i  in  1  abort in-flight operation.
- hi_we_i  in  1  MTHI write enable.
- lo_we_i  in  1  MTLO write enable.
- wdata_i  in  XLEN  MTHI/MTLO data.
- busy_o  out  1  operation in flight; pipeline stalls on it.
- done_o  out  1  one-cycle pulse, result now visible on hi_o/lo_o.
- div0_o  out  1  divide-by-zero pulse (MULDIV_DIV0_EN only; else tied 0).
- hi_o  out  XLEN  HI register.
- lo_o  out  XLEN  LO register.

Behaviour:
- Reset (async, rst_n_i=0): state IDLE, busy_o=0, done_o=0, div0_o=0, hi_o=0, lo_o=0, counter=0.
- States: IDLE, RUN, FIX.
- IDLE: start_i=1 with a mul/div aluop at edge E0 latches op, sign flags, operand magnitudes (signed ops: |x| as 33-bit, so 0x80000000 is exact), clears accumulator, counter=0, -> RUN. start_i with any other aluop ignored (stays IDLE).
- RUN: one iteration per cycle; counter increments; after 32nd iteration (edge E32) -> FIX.
- Multiply: shift-add, 33-bit partial sum, 64-bit product of magnitudes.
- Divide: restoring, compare remainder >= divisor, subtract, shift quotient bit in.
- FIX (edge E33): apply signs. MULT: negate 64-bit product if signs differ. DIV: quotient negated if signs differ, remainder takes sign of dividend (truncation toward zero). Write hi_o=HI, lo_o=LO; -> IDLE.
- Timing: busy_o=1 in cycles after E0 through E33 (33 cycles); done_o=1 for exactly the cycle after E33, busy_o=0 in that cycle; a new start_i is accepted in that same cycle.
- Result mapping: mul HI:LO = product[63:32]:[31:0]; div LO=quotient, HI=remainder.
- 0x80000000 DIV 0xFFFFFFFF: LO=0x80000000, HI=0, no flag.
- Divide by zero (base build): algorithm runs unchanged: unsigned gives LO=0xFFFFFFFF, HI=dividend; signed gives sign-fixed equivalents; full 33-cycle latency.
- start_i while busy_o=1: ignored, no queueing.
- flush_i=1: any state -> IDLE on next edge, busy_o=0, hi_o/lo_o unchanged, no done_o. flush_i has priority over start_i in the same cycle.
- hi_we_i/lo_we_i: applied at edge only when busy_o=0; dropped while busy. Both set: both written. Write and start in same IDLE cycle: write applied, op starts, later result overwrites.
- Reset mid-operation: immediate return to reset values.

Optional Feature:
- MULDIV_DIV0_EN defined: DIV/DIVU with src1_i=0 skips RUN; IDLE -> FIX at E0, completes at E1 with LO=0xFFFFFFFF, HI=src0_i (raw, no sign fix), done_o and div0_o pulsed together for one cycle. Not defined: div0_o tied 0, divide-by-zero follows the base path.

Test Plan:
- MULT src0=0x00000007 src1=0xFFFFFFFD -> after 33 busy cycles done_o pulse, HI=0xFFFFFFFF LO=0xFFFFFFEB.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE LO=0x00000001; back-to-back start in done cycle accepted, busy_o re-asserts next cycle.
- DIV 0xFFFFFFF9 / 0x00000002 -> LO=0xFFFFFFFD HI=0xFFFFFFFF; DIVU 100/7 -> LO=0x0000000E HI=0x00000002; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000 HI=0.
- DIVU 0x12345678 / 0 -> LO=0xFFFFFFFF HI=0x12345678; 33-cycle latency without MULDIV_DIV0_EN, 1-cycle with div0_o=1.
- Preload HI=0xAAAA0000 via hi_we_i, start MULT, flush_i at cycle 10 -> busy_o=0 next cycle, no done_o, HI still 0xAAAA0000; hi_we_i during busy dropped.
- rst_n_i low at cycle 5 of a DIV -> busy_o, hi_o, lo_o immediately 0; start_i with `ALUOP_ADD -> busy_o stays 0.

Source files
------------

// File: rtl/muldiv_seq_if.sv
// Request/result bundle between the pipeline and the muldiv_seq HI/LO sequencer.
// ALUOP codes fall back to local values when defines.v has not already provided them.
`ifndef ALUOP_MULT
`define ALUOP_MULT  5'b11000
`endif
`ifndef ALUOP_MULTU
`define ALUOP_MULTU 5'b11001
`endif
`ifndef ALUOP_DIV
`define ALUOP_DIV   5'b11010
`endif
`ifndef ALUOP_DIVU
`define ALUOP_DIVU  5'b11011
`endif
`ifndef ALUOP_ADD
`define ALUOP_ADD   5'b00000
`endif

interface muldiv_seq_if #(
   parameter int XLEN = 32
);
   logic            start_i;
   logic [4:0]      aluop_i;
   logic [XLEN-1:0] src0_i;
   logic [XLEN-1:0] src1_i;
   logic            flush_i;
   logic            hi_we_i;
   logic            lo_we_i;
   logic [XLEN-1:0] wdata_i;
   logic            busy_o;
   logic            done_o;
   logic            div0_o;
   logic [XLEN-1:0] hi_o;
   logic [XLEN-1:0] lo_o;

   modport master (
      output start_i, aluop_i, src0_i, src1_i, flush_i, hi_we_i, lo_we_i, wdata_i,
      input  busy_o, done_o, div0_o, hi_o, lo_o
   );

   modport slave (
      input  start_i, aluop_i, src0_i, src1_i, flush_i, hi_we_i, lo_we_i, wdata_i,
      output busy_o, done_o, div0_o, hi_o, lo_o
   );
endinterface

// File: rtl/muldiv_seq.sv
// Bit-serial MULT/MULTU/DIV/DIVU sequencer owning HI/LO (XLEN iterations + one sign-fix cycle).
// MULDIV_DIV0_EN: divide by zero short-circuits to a 1-cycle completion with div0_o.
module muldiv_seq #(
   parameter int XLEN = 32
) (
   input logic          clk_i,
   input logic          rst_n_i,
   muldiv_seq_if.slave  bus
);
   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

   state_t          r_state, w_state_next;
   logic [CW-1:0]   r_cnt;
   logic            r_mul, r_neg_q, r_neg_r, r_dz, r_done;
   logic [XLEN-1:0] r_b, r_wh, r_wl, r_hi, r_lo;

   logic            w_is_mul, w_is_div, w_signed, w_accept, w_dz, w_busy, w_fix_wr, w_ge;
   logic [XLEN-1:0] w_mag_a, w_mag_b, w_q_fix, w_r_fix, w_res_hi, w_res_lo;
   logic [XLEN:0]   w_add, w_shift, w_sub;
   logic [2*XLEN-1:0] w_prod_fix;

   assign w_is_mul = (bus.aluop_i == `ALUOP_MULT) || (bus.aluop_i == `ALUOP_MULTU);
   assign w_is_div = (bus.aluop_i == `ALUOP_DIV)  || (bus.aluop_i == `ALUOP_DIVU);
   assign w_signed = (bus.aluop_i == `ALUOP_MULT) || (bus.aluop_i == `ALUOP_DIV);
   assign w_accept = (r_state == S_IDLE) && bus.start_i && (w_is_mul || w_is_div) && !bus.flush_i;

   // Magnitudes as unsigned XLEN bits: -0x80000000 wraps to 0x80000000, which is exact.
   assign w_mag_a = (w_signed && bus.src0_i[XLEN-1]) ? -bus.src0_i : bus.src0_i;
   assign w_mag_b = (w_signed && bus.src1_i[XLEN-1]) ? -bus.src1_i : bus.src1_i;

`ifdef MULDIV_DIV0_EN
   assign w_dz = w_is_div && (bus.src1_i == '0);
`else
   assign w_dz = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) r_state <= S_IDLE;
      else          r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      if (bus.flush_i) begin
         w_state_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (w_accept) w_state_next = w_dz ? S_FIX : S_RUN;
            S_RUN:   if (r_cnt == CW'(XLEN-1)) w_state_next = S_FIX;
            S_FIX:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
         endcase
      end
   end

   always_comb begin
      w_busy   = (r_state != S_IDLE);
      w_fix_wr = (r_state == S_FIX) && !bus.flush_i;
   end

   // Shift-add step (low word holds the multiplier) and restoring-divide step (low word holds dividend/quotient).
   assign w_add   = {1'b0, r_wh} + (r_wl[0] ? {1'b0, r_b} : '0);
   assign w_shift = {r_wh, r_wl[XLEN-1]};
   assign w_sub   = w_shift - {1'b0, r_b};
   assign w_ge    = (w_shift >= {1'b0, r_b});

   assign w_prod_fix = r_neg_q ? -{r_wh, r_wl} : {r_wh, r_wl};
   assign w_q_fix    = r_neg_q ? -r_wl : r_wl;
   assign w_r_fix    = r_neg_r ? -r_wh : r_wh;
   assign w_res_hi   = r_dz ? r_wh : (r_mul ? w_prod_fix[2*XLEN-1:XLEN] : w_r_fix);
   assign w_res_lo   = r_dz ? r_wl : (r_mul ? w_prod_fix[XLEN-1:0]      : w_q_fix);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_cnt   <= '0;
         r_mul   <= 1'b0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_dz    <= 1'b0;
         r_b     <= '0;
         r_wh    <= '0;
         r_wl    <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_done  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_cnt   <= '0;
            r_mul   <= w_is_mul;
            r_neg_q <= w_signed && (bus.src0_i[XLEN-1] ^ bus.src1_i[XLEN-1]);
            r_neg_r <= w_signed && bus.src0_i[XLEN-1];
            r_dz    <= w_dz;
            r_b     <= w_mag_b;
            r_wh    <= w_dz ? bus.src0_i : '0;
            r_wl    <= w_dz ? '1 : w_mag_a;
         end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_mul) begin
               r_wh <= w_add[XLEN:1];
               r_wl <= {w_add[0], r_wl[XLEN-1:1]};
            end else begin
               r_wh <= w_ge ? w_sub[XLEN-1:0] : w_shift[XLEN-1:0];
               r_wl <= {r_wl[XLEN-2:0], w_ge};
            end
         end

         // MTHI/MTLO only land while idle; a finishing operation owns HI/LO on its FIX edge.
         if (w_fix_wr) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
         end else if (!w_busy) begin
            if (bus.hi_we_i) r_hi <= bus.wdata_i;
            if (bus.lo_we_i) r_lo <= bus.wdata_i;
         end
         r_done <= w_fix_wr;
      end
   end

`ifdef MULDIV_DIV0_EN
   logic r_div0;
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) r_div0 <= 1'b0;
      else          r_div0 <= w_fix_wr && r_dz;
   end
   assign bus.div0_o = r_div0;
`else
   assign bus.div0_o = 1'b0;
`endif

   assign bus.busy_o = w_busy;
   assign bus.done_o = r_done;
   assign bus.hi_o   = r_hi;
   assign bus.lo_o   = r_lo;
endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: vector table, corner-case sequences, randomized ops vs. arithmetic model.
`ifndef ALUOP_MULT
`define ALUOP_MULT  5'b11000
`endif
`ifndef ALUOP_MULTU
`define ALUOP_MULTU 5'b11001
`endif
`ifndef ALUOP_DIV
`define ALUOP_DIV   5'b11010
`endif
`ifndef ALUOP_DIVU
`define ALUOP_DIVU  5'b11011
`endif
`ifndef ALUOP_ADD
`define ALUOP_ADD   5'b00000
`endif

module tb_muldiv_seq;
   localparam logic [4:0] OP_MULT  = `ALUOP_MULT;
   localparam logic [4:0] OP_MULTU = `ALUOP_MULTU;
   localparam logic [4:0] OP_DIV   = `ALUOP_DIV;
   localparam logic [4:0] OP_DIVU  = `ALUOP_DIVU;
   localparam logic [4:0] OP_ADD   = `ALUOP_ADD;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   failed = 0;

   always #5 clk = ~clk;

   muldiv_seq_if #(.XLEN(32)) bus ();

   muldiv_seq #(.XLEN(32)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] eh;
      logic [31:0] el;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference arithmetic: plain 64-bit products and truncating division.
   function automatic logic [63:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      logic [63:0] p;
      logic [31:0] q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p = '0;
      q = '0;
      r = '0;
      if (op == OP_MULT) begin
         p = 64'(sa * sb);
      end else if (op == OP_MULTU) begin
         p = {32'b0, a} * {32'b0, b};
      end else begin
         if (b == 0) begin
`ifdef MULDIV_DIV0_EN
            q = 32'hFFFF_FFFF;
            r = a;
`else
            q = (op == OP_DIV && a[31]) ? -32'hFFFF_FFFF : 32'hFFFF_FFFF;
            r = a;
`endif
         end else if (op == OP_DIV) begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
         end else begin
            q = a / b;
            r = a % b;
         end
         p = {r, q};
      end
      return p;
   endfunction

   // Called just after a falling edge; returns at the falling edge of the done cycle.
   task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el);
      int lat;
      bit seen;
      bit exp_dz;
      exp_dz = 1'b0;
`ifdef MULDIV_DIV0_EN
      exp_dz = (op == OP_DIV || op == OP_DIVU) && (b == 0);
`endif
      bus.start_i = 1'b1;
      bus.aluop_i = op;
      bus.src0_i  = a;
      bus.src1_i  = b;
      @(posedge clk);
      #1;
      bus.start_i = 1'b0;
      chk("busy_after_start", 64'(bus.busy_o), 64'd1);
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 100) begin
         @(negedge clk);
         if (bus.done_o) seen = 1'b1;
         else            lat++;
      end
      chk("done_seen", 64'(seen), 64'd1);
      chk("latency", 64'(lat), exp_dz ? 64'd1 : 64'd33);
      chk("busy_in_done", 64'(bus.busy_o), 64'd0);
      chk("div0", 64'(bus.div0_o), 64'(exp_dz));
      chk("hi", 64'(bus.hi_o), 64'(eh));
      chk("lo", 64'(bus.lo_o), 64'(el));
      $display("[TB] op=%b a=%h b=%h -> hi=%h lo=%h lat=%0d", op, a, b, bus.hi_o, bus.lo_o, lat);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int ndone;
      int n;
      logic [4:0] ops[4];
      logic [63:0] e;
      logic [4:0] rop;
      logic [31:0] ra, rb;

      ops[0] = OP_MULT; ops[1] = OP_MULTU; ops[2] = OP_DIV; ops[3] = OP_DIVU;

      vecs[0] = '{OP_MULT,  32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
      vecs[1] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[3] = '{OP_DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E};
      vecs[4] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
      vecs[5] = '{OP_DIVU,  32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF};

      bus.start_i = 1'b0; bus.aluop_i = '0; bus.src0_i = '0; bus.src1_i = '0;
      bus.flush_i = 1'b0; bus.hi_we_i = 1'b0; bus.lo_we_i = 1'b0; bus.wdata_i = '0;

      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(bus.busy_o), 64'd0);
      chk("rst_done", 64'(bus.done_o), 64'd0);
      chk("rst_div0", 64'(bus.div0_o), 64'd0);
      chk("rst_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Back-to-back: each vector starts in the done cycle of the previous one.
      for (int i = 0; i < 6; i++)
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el);

      // MTHI/MTLO together, then flush a MULT mid-flight while MTHI is attempted.
      @(negedge clk);
      bus.hi_we_i = 1'b1; bus.lo_we_i = 1'b1; bus.wdata_i = 32'hAAAA_0000;
      @(posedge clk); #1;
      bus.hi_we_i = 1'b0; bus.lo_we_i = 1'b0;
      chk("mthi_mtlo_both", {bus.hi_o, bus.lo_o}, {32'hAAAA_0000, 32'hAAAA_0000});
      @(negedge clk);
      bus.start_i = 1'b1; bus.aluop_i = OP_MULT; bus.src0_i = 32'd7; bus.src1_i = 32'd3;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      bus.hi_we_i = 1'b1; bus.wdata_i = 32'h1234_5678;
      repeat (9) @(negedge clk);
      bus.hi_we_i = 1'b0;
      bus.flush_i = 1'b1;
      @(posedge clk); #1;
      bus.flush_i = 1'b0;
      chk("flush_busy", 64'(bus.busy_o), 64'd0);
      chk("flush_hi_kept", 64'(bus.hi_o), 64'hAAAA_0000);
      chk("flush_lo_kept", 64'(bus.lo_o), 64'hAAAA_0000);
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.done_o) ndone++;
      end
      chk("flush_no_done", 64'(ndone), 64'd0);
      $display("[TB] flush sequence: hi=%h lo=%h", bus.hi_o, bus.lo_o);

      // flush beats start in the same idle cycle
      bus.start_i = 1'b1; bus.aluop_i = OP_MULTU; bus.flush_i = 1'b1;
      @(posedge clk); #1;
      bus.start_i = 1'b0; bus.flush_i = 1'b0;
      chk("flush_over_start", 64'(bus.busy_o), 64'd0);
      $display("[TB] flush+start same cycle: busy=%b", bus.busy_o);

      // MTHI and start together: write lands, result later overwrites it.
      @(negedge clk);
      bus.hi_we_i = 1'b1; bus.wdata_i = 32'hDEAD_BEEF;
      bus.start_i = 1'b1; bus.aluop_i = OP_MULTU; bus.src0_i = 32'd2; bus.src1_i = 32'd3;
      @(posedge clk); #1;
      bus.hi_we_i = 1'b0; bus.start_i = 1'b0;
      chk("write_with_start_hi", 64'(bus.hi_o), 64'hDEAD_BEEF);
      chk("write_with_start_busy", 64'(bus.busy_o), 64'd1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.done_o && n < 100);
      chk("write_with_start_done", 64'(bus.done_o), 64'd1);
      chk("write_with_start_result", {bus.hi_o, bus.lo_o}, 64'd6);
      $display("[TB] write+start: hi=%h lo=%h", bus.hi_o, bus.lo_o);

      // Async reset at cycle 5 of a DIV.
      @(negedge clk);
      bus.start_i = 1'b1; bus.aluop_i = OP_DIV; bus.src0_i = 32'd100; bus.src1_i = 32'd7;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", 64'(bus.busy_o), 64'd0);
      chk("midrst_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b1; bus.aluop_i = OP_ADD;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      chk("add_ignored_busy", 64'(bus.busy_o), 64'd0);
      repeat (3) @(negedge clk);
      chk("add_ignored_done", 64'(bus.done_o), 64'd0);
      $display("[TB] reset mid-DIV + ALUOP_ADD: busy=%b hi=%h lo=%h", bus.busy_o, bus.hi_o, bus.lo_o);

      // Randomized ops against the arithmetic model, including zero and small divisors.
      @(negedge clk);
      for (int i = 0; i < 40; i++) begin
         rop = ops[$urandom_range(0, 3)];
         ra  = $urandom;
         rb  = $urandom;
         if ($urandom_range(0, 9) == 0)      rb = 32'd0;
         else if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 15));
         if ($urandom_range(0, 7) == 0)      ra = 32'h8000_0000;
         e = model(rop, ra, rb);
         do_op(rop, ra, rb, e[63:32], e[31:0]);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
